// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared depth, default sync byte and state encodings
package prog_loader_pkg;

    localparam int          PROG_DEPTH        = 16;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LOAD,
        CHECK,
        RUN
    } load_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// rtl/prog_loader_uart_rx.sv - 8N1 serial receiver for the program loader
// Ports: CLK/RST clock and async reset, RXD raw serial line,
//        DATA received byte, VALID one-cycle byte strobe, FERR one-cycle framing error.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL = CW'(CLK_DIV - 1);

    rx_state_t     state;
    logic [1:0]    sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            DATA    <= '0;
            VALID   <= 1'b0;
            FERR    <= 1'b0;
        end else begin
            sync    <= {sync[0], RXD};
            rx_prev <= rx_s;
            VALID   <= 1'b0;
            FERR    <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Mid-bit recheck rejects short glitches silently.
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            DATA  <= shift;
                            VALID <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            FERR  <= 1'b1;
                            state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A broken frame leaves the line low; only a return to idle re-arms.
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader with checksum and CPU hold control
// Ports: CLK/RST clock and async reset, RXD serial program stream, ADDR CPU program counter,
//        COMMAND instruction at ADDR, CPU_HOLD keeps CPU halted, LOADED last load good,
//        ERR sticky load error, BUSY load or checksum phase in progress.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         CLK_DIV   = 16,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    input  logic [3:0] ADDR,
    output logic [7:0] COMMAND,
    output logic       CPU_HOLD,
    output logic       LOADED,
    output logic       ERR,
    output logic       BUSY
);

    load_state_t state;
    logic [3:0]  idx;
    logic [7:0]  sum;
    logic [7:0]  ram [PROG_DEPTH];
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;

    uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .CLK   (CLK),
        .RST   (RST),
        .RXD   (RXD),
        .DATA  (rx_data),
        .VALID (rx_valid),
        .FERR  (rx_ferr)
    );

    assign COMMAND  = ram[ADDR];
    assign CPU_HOLD = (state != RUN);
    assign BUSY     = (state == LOAD) || (state == CHECK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= WAIT_SYNC;
            idx    <= '0;
            sum    <= '0;
            LOADED <= 1'b0;
            ERR    <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++) begin
                ram[i] <= 8'h00;
            end
        end else if (rx_ferr) begin
            state <= WAIT_SYNC;
            ERR   <= 1'b1;
        end else if (rx_valid) begin
            case (state)
                WAIT_SYNC, RUN: begin
                    if (rx_data == SYNC_BYTE) begin
                        state  <= LOAD;
                        idx    <= '0;
                        sum    <= '0;
                        LOADED <= 1'b0;
                        ERR    <= 1'b0;
                    end
                end
                LOAD: begin
                    // Sync byte value is ordinary data here.
                    ram[idx] <= rx_data;
                    sum      <= sum + rx_data;
                    idx      <= idx + 4'd1;
                    if (idx == 4'hF) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (rx_data == sum) begin
                        state  <= RUN;
                        LOADED <= 1'b1;
                    end else begin
                        state  <= WAIT_SYNC;
                        ERR    <= 1'b1;
                        LOADED <= 1'b0;
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

    localparam int CLK_DIV = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic [3:0] ADDR = 4'd0;
    logic [7:0] COMMAND;
    logic       CPU_HOLD;
    logic       LOADED;
    logic       ERR;
    logic       BUSY;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_valid_cyc = 0;
    int hold_fall_cyc  = -100;
    logic prev_hold = 1'b1;

    logic [7:0] sb [$];
    logic [7:0] model [16];
    logic [7:0] seq_data [16];

    prog_loader #(
        .CLK_DIV   (CLK_DIV),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RXD      (RXD),
        .ADDR     (ADDR),
        .COMMAND  (COMMAND),
        .CPU_HOLD (CPU_HOLD),
        .LOADED   (LOADED),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every received byte must match the next byte sent with a good stop bit.
    always @(negedge CLK) begin
        if (dut.u_rx.VALID) begin
            last_valid_cyc = cyc;
            if (sb.size() == 0)
                check("rx_unexpected", {24'h0, dut.u_rx.DATA}, 32'h100);
            else
                check("rx_byte", {24'h0, dut.u_rx.DATA}, {24'h0, sb.pop_front()});
        end
        if (prev_hold && !CPU_HOLD) hold_fall_cyc = cyc;
        prev_hold = CPU_HOLD;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge CLK); #1;
        RXD = 1'b0;
        repeat (CLK_DIV) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CLK_DIV) @(posedge CLK);
        end
        RXD = stop_bit;
        repeat (CLK_DIV) @(posedge CLK);
        RXD = 1'b1;
        repeat (CLK_DIV + 4) @(posedge CLK);
        #1;
    endtask

    task automatic send_good(input logic [7:0] b);
        sb.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        #3;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < 16; a++) begin
            ADDR = 4'(a);
            #1;
            check(tag, {24'h0, COMMAND}, {24'h0, model[a]});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hold"},   {31'h0, CPU_HOLD}, 32'd1);
        check({tag, "_loaded"}, {31'h0, LOADED},   32'd0);
        check({tag, "_err"},    {31'h0, ERR},      32'd0);
        check({tag, "_busy"},   {31'h0, BUSY},     32'd0);
        for (int a = 0; a < 16; a++) model[a] = 8'h00;
        check_ram({tag, "_ram"});
    endtask

    // Sync byte, 16 data bytes, then the given checksum byte.
    task automatic do_load(input logic [7:0] csum);
        send_good(8'hA5);
        check("busy_after_sync", {31'h0, BUSY}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_good(seq_data[i]);
            check("busy_in_load", {31'h0, BUSY}, 32'd1);
        end
        send_good(csum);
        check("busy_after_csum", {31'h0, BUSY}, 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("rst");

        // Good load 00..0F, checksum 0x78.
        for (int i = 0; i < 16; i++) seq_data[i] = 8'(i);
        do_load(8'h78);
        check("good_hold",   {31'h0, CPU_HOLD}, 32'd0);
        check("good_loaded", {31'h0, LOADED},   32'd1);
        check("good_err",    {31'h0, ERR},      32'd0);
        check("hold_latency", 32'(hold_fall_cyc - last_valid_cyc), 32'd1);
        ADDR = 4'd5; #1;
        check("addr5_cmd", {24'h0, COMMAND}, 32'h05);
        for (int i = 0; i < 16; i++) model[i] = seq_data[i];
        check_ram("good_ram");

        // RUN: non-sync byte ignored, sync restarts a load.
        send_good(8'h3C);
        check("run_3c_hold",   {31'h0, CPU_HOLD}, 32'd0);
        check("run_3c_loaded", {31'h0, LOADED},   32'd1);
        send_good(8'hA5);
        check("run_a5_hold",   {31'h0, CPU_HOLD}, 32'd1);
        check("run_a5_loaded", {31'h0, LOADED},   32'd0);
        check("run_a5_busy",   {31'h0, BUSY},     32'd1);

        // Continue that load with a wrong checksum (sync already sent).
        for (int i = 0; i < 16; i++) send_good(seq_data[i]);
        send_good(8'h77);
        check("bad_err",    {31'h0, ERR},      32'd1);
        check("bad_loaded", {31'h0, LOADED},   32'd0);
        check("bad_hold",   {31'h0, CPU_HOLD}, 32'd1);
        check("bad_busy",   {31'h0, BUSY},     32'd0);
        check_ram("bad_ram");
        send_good(8'h12);
        check("ign_err",  {31'h0, ERR},  32'd1);
        check("ign_busy", {31'h0, BUSY}, 32'd0);
        check_ram("ign_ram");

        // Framing error on a sync byte, then recovery with a good sync.
        pulse_reset();
        send_frame(8'hA5, 1'b0);
        check("ferr_err",  {31'h0, ERR},  32'd1);
        check("ferr_busy", {31'h0, BUSY}, 32'd0);
        send_good(8'hA5);
        check("ferr_resume_busy", {31'h0, BUSY}, 32'd1);
        check("ferr_resume_err",  {31'h0, ERR},  32'd0);

        // Short glitch produces neither a byte nor an error.
        pulse_reset();
        @(posedge CLK); #1;
        RXD = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RXD = 1'b1;
        repeat (3 * CLK_DIV) @(posedge CLK);
        #1;
        check("glitch_err",  {31'h0, ERR},  32'd0);
        check("glitch_busy", {31'h0, BUSY}, 32'd0);

        // Reset in the middle of a load, then a fresh randomised load.
        send_good(8'hA5);
        for (int i = 0; i < 8; i++) send_good(8'hC0 + 8'(i));
        pulse_reset();
        check_reset_state("midrst");
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            seq_data[i] = 8'($urandom_range(0, 255));
            s = s + seq_data[i];
        end
        do_load(s);
        check("fresh_loaded", {31'h0, LOADED},   32'd1);
        check("fresh_hold",   {31'h0, CPU_HOLD}, 32'd0);
        check("fresh_err",    {31'h0, ERR},      32'd0);
        for (int i = 0; i < 16; i++) model[i] = seq_data[i];
        check_ram("fresh_ram");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
